// File: rtl/pc_redirect_unit_pkg.sv
// ============================================================================
// Module : pc_redirect_unit_pkg
// Brief  : Shared widths, flush bit indices, FSM encoding and helpers for the
//          fetch PC redirect unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pc_redirect_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Flush vector bit positions, youngest pipeline register first
    localparam int unsigned FL_IFID  = 0;
    localparam int unsigned FL_IDEX  = 1;
    localparam int unsigned FL_EXMEM = 2;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_redirect_unit_pending_reg.sv
// ============================================================================
// Module : pc_pending_reg
// Brief  : Holds a redirect target that could not be applied because the
//          instruction memory was busy.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_pending_reg
    import pc_redirect_unit_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_addr,
    output logic [WIDTH-1:0] pend_addr,
    output logic             pend_valid
);

    // Load takes precedence so a fresh redirect is never lost to a clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_addr  <= '0;
            pend_valid <= 1'b0;
        end else if (load) begin
            pend_addr  <= load_addr;
            pend_valid <= 1'b1;
        end else if (clear) begin
            pend_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_redirect_unit.sv
// ============================================================================
// Module : pc_redirect_unit
// Brief  : Owns the fetch PC, applies jump/branch redirects (immediately or
//          via a pending register) and drives the wrong-path flush vector.
//          Optional misaligned-target trap: define PC_ALIGN_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned     FLUSH_DEPTH = 3,
    parameter logic [XLEN-1:0] PC_STEP     = 32'd4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pcsrc,
    input  logic [XLEN-1:0]        addr_in,
    input  logic                   stall,
    input  logic                   imem_ready,
    output logic [XLEN-1:0]        pc,
    output logic [XLEN-1:0]        pc_plus4,
    output logic                   fetch_valid,
    output logic [FLUSH_DEPTH-1:0] flush,
    output logic                   redirect_pending
`ifdef PC_ALIGN_CHECK_EN
    ,
    input  logic [XLEN-1:0]        trap_vec,
    output logic                   misalign_trap
`endif
);

    state_t            state;
    logic [XLEN-1:0]   pend_addr;
    logic              pend_valid;
    logic              pend_load;
    logic              pend_clear;
    logic              squash;
    logic [XLEN-1:0]   target;
    logic              target_bad;
    logic [XLEN-1:0]   load_pc;

    assign pc_plus4 = pc + PC_STEP;

    assign pend_load  = (state == ST_RUN)  && pcsrc && !imem_ready;
    assign pend_clear = (state == ST_HOLD) && imem_ready;

    pc_pending_reg #(
        .WIDTH (XLEN)
    ) u_pending (
        .clk        (clk),
        .reset      (reset),
        .load       (pend_load),
        .clear      (pend_clear),
        .load_addr  (addr_in),
        .pend_addr  (pend_addr),
        .pend_valid (pend_valid)
    );

    assign redirect_pending = pend_valid;

    // The target being applied this edge: live request in RUN, latched one in HOLD
    assign target = (state == ST_HOLD) ? pend_addr : addr_in;

`ifdef PC_ALIGN_CHECK_EN
    assign target_bad = is_misaligned(target);
    assign load_pc    = target_bad ? trap_vec : target;
`else
    assign target_bad = 1'b0;
    assign load_pc    = target;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (pcsrc && imem_ready) begin
                        pc <= load_pc;
                    end else if (pcsrc) begin
                        state <= ST_HOLD;
                    end else if (!stall && imem_ready) begin
                        pc <= pc_plus4;
                    end
                end
                ST_HOLD: begin
                    // Redirect outranks both new requests and the hazard hold
                    if (imem_ready) begin
                        pc    <= load_pc;
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic load_edge;
    assign load_edge = ((state == ST_RUN) && pcsrc && imem_ready) || pend_clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            misalign_trap <= 1'b0;
        end else begin
            misalign_trap <= load_edge && target_bad;
        end
    end
`else
    logic unused_bad;
    assign unused_bad = target_bad;
`endif

    assign squash = !reset && ((state == ST_HOLD) || pcsrc);

    for (genvar i = 0; i < FLUSH_DEPTH; i++) begin : g_flush
        assign flush[i] = squash;
    end

    assign fetch_valid = !reset && (state == ST_RUN) && !pcsrc && !stall && imem_ready;

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
// ============================================================================
// Module : tb_pc_redirect_unit
// Brief  : Vector table, corner sequences and random run against a model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pcsrc;
    logic [31:0] addr_in;
    logic        stall;
    logic        imem_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic [2:0]  flush;
    logic        redirect_pending;
`ifdef PC_ALIGN_CHECK_EN
    logic [31:0] trap_vec;
    logic        misalign_trap;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: architectural PC plus an outstanding redirect, if any
    logic [31:0] m_pc;
    bit          m_waiting;
    logic [31:0] m_target;
    bit          m_trap;

    pc_redirect_unit dut (
        .clk              (clk),
        .reset            (reset),
        .pcsrc            (pcsrc),
        .addr_in          (addr_in),
        .stall            (stall),
        .imem_ready       (imem_ready),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .fetch_valid      (fetch_valid),
        .flush            (flush),
        .redirect_pending (redirect_pending)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .trap_vec         (trap_vec),
        .misalign_trap    (misalign_trap)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc      = 32'h0;
        m_waiting = 0;
        m_target  = 32'h0;
        m_trap    = 0;
    endtask

    function automatic logic [31:0] landing(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) return trap_vec;
`endif
        return a;
    endfunction

    function automatic bit bad_target(input logic [31:0] a);
`ifdef PC_ALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0 & a[0];
`endif
    endfunction

    // Advance the model across one rising edge using the current inputs
    task automatic model_step();
        m_trap = 0;
        if (m_waiting) begin
            if (imem_ready) begin
                m_pc      = landing(m_target);
                m_trap    = bad_target(m_target);
                m_waiting = 0;
            end
        end else if (pcsrc) begin
            if (imem_ready) begin
                m_pc   = landing(addr_in);
                m_trap = bad_target(addr_in);
            end else begin
                m_waiting = 1;
                m_target  = addr_in;
            end
        end else if (!stall && imem_ready) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic model_check();
        bit exp_squash;
        exp_squash = m_waiting || pcsrc;
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("flush", {29'd0, flush}, exp_squash ? 32'd7 : 32'd0);
        chk("fetch_valid", {31'd0, fetch_valid},
            {31'd0, !m_waiting && !pcsrc && !stall && imem_ready});
        chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_waiting});
`ifdef PC_ALIGN_CHECK_EN
        chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, m_trap});
`endif
    endtask

    task automatic drive(input logic p, input logic [31:0] a, input logic s, input logic r);
        pcsrc      = p;
        addr_in    = a;
        stall      = s;
        imem_ready = r;
    endtask

    typedef struct {
        logic        pcsrc;
        logic [31:0] addr;
        logic        stall;
        logic        ready;
        logic [31:0] exp_pc;
        logic [2:0]  exp_flush;
        logic        exp_fv;
        logic        exp_pend;
    } vec_t;

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h000, 3'b000, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h004, 3'b000, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h008, 3'b000, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h00C, 3'b000, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h010, 3'b000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h010, 3'b000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h010, 3'b000, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 32'h200, 1'b0, 1'b1, 32'h014, 3'b111, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h200, 3'b000, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 32'h400, 1'b0, 1'b0, 32'h204, 3'b111, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'h400, 1'b0, 1'b0, 32'h204, 3'b111, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 32'h400, 1'b1, 1'b0, 32'h204, 3'b111, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 3'b111, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h400, 3'b000, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 32'h80,  1'b1, 1'b1, 32'h404, 3'b111, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h080, 3'b000, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 32'h0,   1'b0, 1'b1, 32'h084, 3'b000, 1'b1, 1'b0};

        reset = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
        trap_vec = 32'h8000_0000;
`endif
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        model_reset();
        #1;
        chk("reset_pc", pc, 32'h0);
        chk("reset_fv", {31'd0, fetch_valid}, 32'd0);
        chk("reset_flush", {29'd0, flush}, 32'd0);
        chk("reset_pend", {31'd0, redirect_pending}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].pcsrc, vecs[i].addr, vecs[i].stall, vecs[i].ready);
            #2;
            chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("vec%0d_pc4", i), pc_plus4, vecs[i].exp_pc + 32'd4);
            chk($sformatf("vec%0d_flush", i), {29'd0, flush}, {29'd0, vecs[i].exp_flush});
            chk($sformatf("vec%0d_fv", i), {31'd0, fetch_valid}, {31'd0, vecs[i].exp_fv});
            chk($sformatf("vec%0d_pend", i), {31'd0, redirect_pending}, {31'd0, vecs[i].exp_pend});
            model_step();
            @(negedge clk);
        end

        // Wrap-around at the top of the address space
        drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        model_step();
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        #2;
        chk("wrap_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        model_step();
        @(negedge clk);
        #2;
        chk("wrap_next", pc, 32'h0);

        // Async reset while a redirect is held
        @(negedge clk);
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("hold_pend", {31'd0, redirect_pending}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_pend", {31'd0, redirect_pending}, 32'd0);
        chk("async_flush", {29'd0, flush}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

`ifdef PC_ALIGN_CHECK_EN
        drive(1'b1, 32'h102, 1'b0, 1'b1);
        model_step();
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        chk("trap_pc", pc, 32'h8000_0000);
        chk("trap_pulse", {31'd0, misalign_trap}, 32'd1);
        model_step();
        @(negedge clk);
        #2;
        chk("trap_clear", {31'd0, misalign_trap}, 32'd0);
        @(negedge clk);
`endif

        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
`ifdef PC_ALIGN_CHECK_EN
            trap_vec = {$urandom_range(0, 32'hFFFF), 16'h0};
`endif
            drive($urandom_range(0, 5) == 0, a, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 3) != 0);
            #2;
            model_check();
            model_step();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Receiving end of the redirect interface: consumes the merged pcsrc / addr_out pair and owns the architectural fetch PC.
- Sequences the PC: +4 per accepted fetch, holds on stall or instruction-memory wait, and loads the redirect target.
- A redirect that arrives while memory is busy is held in a pending register until it can be applied.
- Generates the wrong-path flush vector for the pipeline registers between IF and the resolving stage (MEM).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_DEPTH, 3, number of pipeline registers squashed on redirect: bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- pcsrc  input  1  redirect request from jump/branch merge logic.
- addr_in  input  32  redirect target; valid only when pcsrc=1.
- stall  input  1  load-use hold from the hazard unit.
- imem_ready  input  1  instruction memory accepted this cycle's fetch.
- pc  output  32  current fetch address, to imem and IF/ID.
- pc_plus4  output  32  pc + PC_STEP, combinational.
- fetch_valid  output  1  the instruction at pc is on the correct path and accepted.
- flush  output  FLUSH_DEPTH  squash pulse to pipeline registers.
- redirect_pending  output  1  a latched redirect is waiting for imem_ready.

Behaviour:
- Reset (async, any state): pc=RESET_PC, pend_valid=0, pend_addr=0, state=RUN, flush=0, fetch_valid=0.
- States:
  - RUN: normal fetch.
  - HOLD: redirect latched, waiting on imem.
- Next-PC priority, evaluated each edge in RUN:
  1. pcsrc=1 and imem_ready=1: pc <= addr_in; stay in RUN.
  2. pcsrc=1 and imem_ready=0: pend_addr <= addr_in; pend_valid <= 1; go to HOLD; pc unchanged.
  3. stall=1 or imem_ready=0: pc unchanged.
  4. Otherwise: pc <= pc + PC_STEP. Wraps modulo 2^32, so 32'hFFFF_FFFC advances to 0.
- HOLD:
  - Further pcsrc is ignored. Upstream guarantees pcsrc deasserts once the pipeline is flushed.
  - stall is ignored, because the redirect outranks the hazard hold.
  - When imem_ready=1: pc <= pend_addr, pend_valid <= 0, go to RUN.
- flush:
  - Combinational: all ones in any cycle where pcsrc=1 in RUN, zero otherwise.
  - Exactly one cycle per accepted redirect request.
  - Also all ones in HOLD, so wrong-path instructions cannot advance while the redirect waits.
- fetch_valid: asserted when state=RUN, pcsrc=0, stall=0 and imem_ready=1; low otherwise.
- redirect_pending: equals pend_valid.
- Latency: redirect target appears on pc one edge after pcsrc (memory ready), or one edge after imem_ready rises (HOLD).
- Simultaneous pcsrc and stall: redirect wins, and the stall is dropped for that cycle.
- Misaligned addr_in: loaded as-is unless the optional feature is compiled in.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Adds input trap_vec[31:0] and output misalign_trap (1 bit).
  - A redirect with addr_in[1:0] != 0 loads trap_vec instead of addr_in, still asserts flush, and pulses misalign_trap for one cycle, registered on the loading edge.
  - A misaligned redirect latched in HOLD is checked when it is applied.
- Undefined: ports absent; target is loaded unchecked.

Decomposition:
- Shared package:
  - XLEN=32 and RESET_PC default.
  - Flush bit index constants FL_IFID=0, FL_IDEX=1, FL_EXMEM=2.
  - State encoding for RUN/HOLD.
- Sub-module: pc_pending_reg, holding pend_addr/pend_valid with load/clear. This makes the hold path independently testable.
- Everything else (next-PC mux, FSM, flush/valid decode) stays in the top.

Test Plan:
- Reset then 3 cycles with imem_ready=1, no stall -> pc 0x0, 0x4, 0x8, 0xC; fetch_valid=1; flush=0.
- At pc=0x10, stall=1 for 2 cycles -> pc holds 0x10; fetch_valid=0; resumes at 0x14.
- pcsrc=1, addr_in=0x0000_0200, imem_ready=1 -> flush=3'b111 for one cycle; next pc=0x200; then 0x204.
- pcsrc=1, addr_in=0x400 with imem_ready=0 for 3 cycles -> redirect_pending=1 and flush=3'b111 throughout; pc unchanged; pc=0x400 on the edge after imem_ready rises.
- pcsrc=1 and stall=1 together, addr_in=0x80 -> pc=0x80 next cycle, stall ignored.
- pc=0xFFFF_FFFC advance -> pc=0x0.
- Async reset asserted mid-HOLD -> pc=RESET_PC immediately (no clock edge); redirect_pending=0.
- With PC_ALIGN_CHECK_EN: addr_in=0x102, trap_vec=0x8000_0000 -> pc=0x8000_0000 and misalign_trap=1 for one cycle.
